fifo_uart_tx: RTL

- Serial UART transmitter that drains the read side of the TX async FIFO in the read-clock domain.
- Pops one word when the FIFO is non-empty, then frames it as start / data / optional parity / stop.
- Sends frames back-to-back while data remains.
- R_CLK is already the divided bit clock: one bit per R_CLK cycle.

---
 rtl/fifo_uart_tx.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - UART transmitter draining the read side of the TX async FIFO
module fifo_uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  R_CLK,
    input  logic                  R_RST,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  rinc,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  r_par_en;
    logic                  w_par_en_nxt;
    logic                  r_par_bit;
    logic                  w_par_bit_nxt;
    logic                  r_tx;
    logic                  w_tx_nxt;
    logic                  r_busy;
    logic                  w_busy_nxt;
    logic                  r_rinc;
    logic                  w_rinc_nxt;
    logic                  w_pop;

    // A word may only be popped between frames (IDLE) or in the stop bit, so a
    // stale rempty right after a pop is never sampled while a frame is in flight.
    assign w_pop = ((r_state == IDLE) || (r_state == STOP)) && !rempty;

    // State, datapath and registered line outputs.
    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_rinc    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_cnt     <= w_cnt_nxt;
            r_par_en  <= w_par_en_nxt;
            r_par_bit <= w_par_bit_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= w_busy_nxt;
            r_rinc    <= w_rinc_nxt;
        end
    end

    // Next-state logic; TX value computed here is the bit shown during the next state.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_cnt_nxt     = r_cnt;
        w_par_en_nxt  = r_par_en;
        w_par_bit_nxt = r_par_bit;
        w_tx_nxt      = 1'b1;
        w_busy_nxt    = 1'b1;
        w_rinc_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                w_busy_nxt = 1'b0;
            end
            START: begin
                w_state_nxt = DATA;
                w_cnt_nxt   = '0;
                w_tx_nxt    = r_shift[0];
            end
            DATA: begin
                if (r_cnt == LAST_BIT) begin
                    if (r_par_en) begin
                        w_state_nxt = PARITY;
                        w_tx_nxt    = r_par_bit;
                    end else begin
                        w_state_nxt = STOP;
                    end
                end else begin
                    // Shift right so the next bit to send always sits in bit 1.
                    w_cnt_nxt   = r_cnt + CW'(1);
                    w_shift_nxt = r_shift >> 1;
                    w_tx_nxt    = r_shift[1];
                end
            end
            PARITY: begin
                w_state_nxt = STOP;
            end
            STOP: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase

        // Pop overrides IDLE/STOP handling so frames run back-to-back with no gap.
        if (w_pop) begin
            w_state_nxt   = START;
            w_shift_nxt   = rdata;
            w_par_en_nxt  = PAR_EN;
            w_par_bit_nxt = (^rdata) ^ PAR_TYP;
            w_rinc_nxt    = 1'b1;
            w_busy_nxt    = 1'b1;
            w_tx_nxt      = 1'b0;
        end
    end

    assign TX_OUT = r_tx;
    assign busy   = r_busy;
    assign rinc   = r_rinc;

endmodule
